// File: rtl/photon_pulse_counter.sv
// Gated photon pulse counter: synchronizes and width-qualifies detector pulses,
// then reports one scaled, clipped count per gate window plus a running total.
module photon_pulse_counter #(
   parameter int unsigned GATE_CYCLES = 5_000_000,
   parameter int unsigned MIN_WIDTH   = 2,
   parameter int unsigned SCALE_SHIFT = 0,
   parameter int unsigned OUT_MAX     = 216
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        en,
   input  logic        iPulse,
   output logic [15:0] oPulseCounter,
   output logic        oDataUpdate,
   output logic        oClipped,
   output logic        oWinOverflow,
   output logic [31:0] oTotalCount
);

   localparam int unsigned CNT_W  = 16;
   localparam int unsigned TOT_W  = 32;
   localparam int unsigned GATE_W = 32;
   localparam int unsigned WID_W  = 4;

   localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);
   localparam logic [WID_W-1:0]  QUAL_AT   = WID_W'(MIN_WIDTH - 1);
   localparam logic [WID_W-1:0]  WID_MAX   = '1;
   localparam logic [CNT_W-1:0]  CLIP_MAX  = CNT_W'(OUT_MAX);
   localparam logic [CNT_W-1:0]  WIN_MAX   = '1;
   localparam logic [TOT_W-1:0]  TOT_MAX   = '1;

   logic              sync_q;
   logic              p_s;
   logic [WID_W-1:0]  width_q;
   logic [GATE_W-1:0] gate_q;
   logic [CNT_W-1:0]  win_q;
   logic              ovf_q;

   logic              qualify_c;
   logic              terminal_c;
   logic [CNT_W-1:0]  scaled_c;
   logic              clip_c;

   // Qualifies once per high level: the width counter saturates below wrap.
   assign qualify_c  = p_s && (width_q == QUAL_AT);
   assign terminal_c = (gate_q == GATE_LAST);
   assign scaled_c   = win_q >> SCALE_SHIFT;
   assign clip_c     = (scaled_c > CLIP_MAX);

   // Two-flop synchronizer, independent of en
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= 1'b0;
         p_s    <= 1'b0;
      end else begin
         sync_q <= iPulse;
         p_s    <= sync_q;
      end
   end

   // Width counter of the synchronized high level
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         width_q <= '0;
      end else if (!p_s) begin
         width_q <= '0;
      end else if (width_q != WID_MAX) begin
         width_q <= width_q + WID_W'(1);
      end
   end

   // Gate window timer, held at zero while disabled
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         gate_q <= '0;
      end else if (!en || terminal_c) begin
         gate_q <= '0;
      end else begin
         gate_q <= gate_q + GATE_W'(1);
      end
   end

   // Window count; a pulse on the terminal cycle opens the next window at 1
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         win_q <= '0;
         ovf_q <= 1'b0;
      end else if (terminal_c) begin
         win_q <= CNT_W'(en && qualify_c);
         ovf_q <= 1'b0;
      end else if (!en) begin
         win_q <= '0;
         ovf_q <= 1'b0;
      end else if (qualify_c) begin
         if (win_q == WIN_MAX) begin
            ovf_q <= 1'b1;
         end else begin
            win_q <= win_q + CNT_W'(1);
         end
      end
   end

   // Result registers, updated together with the strobe
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         oPulseCounter <= '0;
         oDataUpdate   <= 1'b0;
         oClipped      <= 1'b0;
         oWinOverflow  <= 1'b0;
      end else begin
         oDataUpdate <= terminal_c;
         if (terminal_c) begin
            oPulseCounter <= clip_c ? CLIP_MAX : scaled_c;
            oClipped      <= clip_c;
            oWinOverflow  <= ovf_q;
         end
      end
   end

   // Saturating diagnostic total of enabled qualified pulses
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         oTotalCount <= '0;
      end else if (en && qualify_c && (oTotalCount != TOT_MAX)) begin
         oTotalCount <= oTotalCount + TOT_W'(1);
      end
   end

endmodule

// File: tb/tb_photon_pulse_counter.sv
// Testbench for photon_pulse_counter: three configurations share one stimulus
// stream and are compared against a sample-history reference model.
module tb_photon_pulse_counter;

   localparam int GC   = 100;
   localparam int MINW = 2;

   logic clk = 1'b0;
   logic rst_n, en, iPulse;

   logic [15:0] d_pc  [3];
   logic        d_upd [3];
   logic        d_clip[3];
   logic        d_ovf [3];
   logic [31:0] d_tot [3];

   int tests = 0;
   int fails = 0;

   // Reference model state
   bit q[$];
   int m_e      = 0;
   int m_run    = 0;
   int m_win    = 0;
   int m_total  = 0;
   bit m_strobe = 1'b0;
   int m_exp_pc  [3] = '{0, 0, 0};
   bit m_exp_clip[3] = '{0, 0, 0};
   int cfg_shift [3] = '{0, 1, 0};
   int cfg_max   [3] = '{216, 216, 3};

   int strobe_mis = 0;
   int strobe_cnt = 0;

   always #5 clk = ~clk;

   photon_pulse_counter #(.GATE_CYCLES(GC), .MIN_WIDTH(MINW), .SCALE_SHIFT(0), .OUT_MAX(216)) u_dut (
      .clk(clk), .rst_n(rst_n), .en(en), .iPulse(iPulse),
      .oPulseCounter(d_pc[0]), .oDataUpdate(d_upd[0]), .oClipped(d_clip[0]),
      .oWinOverflow(d_ovf[0]), .oTotalCount(d_tot[0]));

   photon_pulse_counter #(.GATE_CYCLES(GC), .MIN_WIDTH(MINW), .SCALE_SHIFT(1), .OUT_MAX(216)) u_scl (
      .clk(clk), .rst_n(rst_n), .en(en), .iPulse(iPulse),
      .oPulseCounter(d_pc[1]), .oDataUpdate(d_upd[1]), .oClipped(d_clip[1]),
      .oWinOverflow(d_ovf[1]), .oTotalCount(d_tot[1]));

   photon_pulse_counter #(.GATE_CYCLES(GC), .MIN_WIDTH(MINW), .SCALE_SHIFT(0), .OUT_MAX(3)) u_clp (
      .clk(clk), .rst_n(rst_n), .en(en), .iPulse(iPulse),
      .oPulseCounter(d_pc[2]), .oDataUpdate(d_upd[2]), .oClipped(d_clip[2]),
      .oWinOverflow(d_ovf[2]), .oTotalCount(d_tot[2]));

   // Synchronized level seen at edge ei is the raw sample taken two edges earlier
   function automatic bit ps_at(int ei);
      int idx = ei - 3;
      if (idx >= 0 && idx < q.size()) return q[idx];
      return 1'b0;
   endfunction

   task automatic model_edge();
      bit qual;
      bit term;
      int s;
      if (!rst_n) begin
         q.delete();
         m_e = 0; m_run = 0; m_win = 0; m_total = 0; m_strobe = 1'b0;
         return;
      end
      m_e++;
      qual = 1'b1;
      for (int k = 0; k < MINW; k++) if (!ps_at(m_e - k)) qual = 1'b0;
      if (ps_at(m_e - MINW)) qual = 1'b0;
      q.push_back(iPulse);
      term = (m_run % GC) == GC - 1;
      m_strobe = term;
      if (term) begin
         for (int i = 0; i < 3; i++) begin
            s = m_win >> cfg_shift[i];
            m_exp_clip[i] = s > cfg_max[i];
            m_exp_pc[i]   = m_exp_clip[i] ? cfg_max[i] : s;
         end
         m_win = (en && qual) ? 1 : 0;
      end else if (!en) begin
         m_win = 0;
      end else if (qual) begin
         m_win++;
      end
      if (en && qual) m_total++;
      m_run = en ? m_run + 1 : 0;
   endtask

   // Strobe timing against the model, every cycle out of reset
   always @(negedge clk) begin
      if (rst_n) begin
         if (d_upd[0] !== m_strobe || d_upd[1] !== m_strobe || d_upd[2] !== m_strobe)
            strobe_mis <= strobe_mis + 1;
         if (d_upd[0]) strobe_cnt <= strobe_cnt + 1;
      end
   end

   task automatic step(input bit p);
      iPulse = p;
      @(posedge clk);
      model_edge();
      @(negedge clk);
   endtask

   task automatic send(input int hi, input int lo);
      repeat (hi) step(1'b1);
      repeat (lo) step(1'b0);
   endtask

   task automatic wait_strobe(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 400; i++) begin
         if (d_upd[0] === 1'b1) begin
            ok = 1'b1;
            return;
         end
         step(1'b0);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; en = 1'b0; iPulse = 1'b0;
      @(negedge clk);
      step(1'b0);
      step(1'b0);
      tests++; if (d_pc[0] !== 16'd0) begin fails++; $display("FAIL reset_pc got %0d want 0", d_pc[0]); end
      tests++; if (d_upd[0] !== 1'b0) begin fails++; $display("FAIL reset_upd got %b want 0", d_upd[0]); end
      tests++; if (d_clip[0] !== 1'b0) begin fails++; $display("FAIL reset_clip got %b want 0", d_clip[0]); end
      tests++; if (d_ovf[0] !== 1'b0) begin fails++; $display("FAIL reset_ovf got %b want 0", d_ovf[0]); end
      tests++; if (d_tot[0] !== 32'd0) begin fails++; $display("FAIL reset_total got %0d want 0", d_tot[0]); end
      en = 1'b1;
      rst_n = 1'b1;
   endtask

   task automatic test_clean_pulses();
      bit ok;
      repeat (10) send(4, 4);
      wait_strobe(ok);
      tests++; if (!ok) begin fails++; $display("FAIL clean_strobe got none want strobe"); end
      tests++; if (m_e != 100) begin fails++; $display("FAIL clean_first_strobe_cycle got %0d want 100", m_e); end
      tests++; if (d_pc[0] !== 16'd10) begin fails++; $display("FAIL clean_count got %0d want 10", d_pc[0]); end
      tests++; if (d_clip[0] !== 1'b0) begin fails++; $display("FAIL clean_clip got %b want 0", d_clip[0]); end
      tests++; if (d_ovf[0] !== 1'b0) begin fails++; $display("FAIL clean_ovf got %b want 0", d_ovf[0]); end
      tests++; if (d_tot[0] !== 32'd10) begin fails++; $display("FAIL clean_total got %0d want 10", d_tot[0]); end
      tests++; if (d_pc[1] !== 16'd5) begin fails++; $display("FAIL clean_scaled got %0d want 5", d_pc[1]); end
      tests++; if (d_pc[2] !== 16'd3 || d_clip[2] !== 1'b1) begin
         fails++; $display("FAIL clean_clipcfg got %0d/%b want 3/1", d_pc[2], d_clip[2]);
      end
   endtask

   task automatic test_glitch();
      bit ok;
      repeat (6) send(1, 3);
      send(5, 3);
      wait_strobe(ok);
      tests++; if (!ok || d_pc[0] !== 16'd1) begin fails++; $display("FAIL glitch_count got %0d want 1", d_pc[0]); end
      step(1'b0);
      send(40, 4);
      wait_strobe(ok);
      tests++; if (!ok || d_pc[0] !== 16'd1) begin fails++; $display("FAIL long_high_count got %0d want 1", d_pc[0]); end
      tests++; if (d_tot[0] !== 32'(m_total)) begin fails++; $display("FAIL glitch_total got %0d want %0d", d_tot[0], m_total); end
   endtask

   task automatic test_scale_clip();
      bit ok;
      int used;
      step(1'b0);
      repeat (9) send(4, 4);
      wait_strobe(ok);
      tests++; if (!ok || d_pc[0] !== 16'd9) begin fails++; $display("FAIL scale_raw got %0d want 9", d_pc[0]); end
      tests++; if (d_pc[1] !== 16'd4 || d_clip[1] !== 1'b0) begin
         fails++; $display("FAIL scale_shift1 got %0d/%b want 4/0", d_pc[1], d_clip[1]);
      end
      tests++; if (d_pc[2] !== 16'd3 || d_clip[2] !== 1'b1) begin
         fails++; $display("FAIL scale_clip got %0d/%b want 3/1", d_pc[2], d_clip[2]);
      end
      for (int w = 0; w < 4; w++) begin
         step(1'b0);
         used = 1;
         while (used < 85) begin
            int h = $urandom_range(1, 6);
            int l = $urandom_range(1, 4);
            send(h, l);
            used += h + l;
         end
         wait_strobe(ok);
         tests++; if (!ok) begin fails++; $display("FAIL rand_strobe w%0d got none want strobe", w); end
         for (int i = 0; i < 3; i++) begin
            tests++;
            if (d_pc[i] !== 16'(m_exp_pc[i]) || d_clip[i] !== m_exp_clip[i]) begin
               fails++;
               $display("FAIL rand_window w%0d cfg%0d got %0d/%b want %0d/%b",
                        w, i, d_pc[i], d_clip[i], m_exp_pc[i], m_exp_clip[i]);
            end
         end
         tests++; if (d_tot[0] !== 32'(m_total)) begin fails++; $display("FAIL rand_total got %0d want %0d", d_tot[0], m_total); end
      end
   endtask

   task automatic test_terminal_pulse();
      bit ok;
      step(1'b0);
      repeat (2) send(4, 4);
      repeat (79) step(1'b0);
      repeat (4) step(1'b1);
      wait_strobe(ok);
      tests++; if (!ok || d_pc[0] !== 16'd2) begin fails++; $display("FAIL terminal_closing got %0d want 2", d_pc[0]); end
      step(1'b0);
      wait_strobe(ok);
      tests++; if (!ok || d_pc[0] !== 16'd1) begin fails++; $display("FAIL terminal_next got %0d want 1", d_pc[0]); end
   endtask

   task automatic test_enable();
      bit ok;
      int snap;
      int e_en;
      repeat (3) send(4, 4);
      repeat (26) step(1'b0);
      en = 1'b0;
      snap = strobe_cnt;
      repeat (5) send(4, 4);
      repeat (4) step(1'b0);
      tests++; if (strobe_cnt != snap) begin fails++; $display("FAIL enable_low_strobes got %0d want 0", strobe_cnt - snap); end
      en = 1'b1;
      e_en = m_e + 1;
      repeat (2) send(4, 4);
      wait_strobe(ok);
      tests++; if (!ok || m_e != e_en + 99) begin fails++; $display("FAIL enable_strobe_cycle got %0d want %0d", m_e, e_en + 99); end
      tests++; if (d_pc[0] !== 16'd2) begin fails++; $display("FAIL enable_count got %0d want 2", d_pc[0]); end
      tests++; if (d_tot[0] !== 32'(m_total)) begin fails++; $display("FAIL enable_total got %0d want %0d", d_tot[0], m_total); end
   endtask

   task automatic test_reset_mid();
      bit ok;
      step(1'b0);
      repeat (4) send(4, 4);
      repeat (37) step(1'b0);
      #2 rst_n = 1'b0;
      #1;
      tests++; if (d_pc[0] !== 16'd0 || d_upd[0] !== 1'b0 || d_clip[0] !== 1'b0 || d_ovf[0] !== 1'b0) begin
         fails++; $display("FAIL midreset_outputs got pc=%0d upd=%b clip=%b ovf=%b want 0", d_pc[0], d_upd[0], d_clip[0], d_ovf[0]);
      end
      tests++; if (d_tot[0] !== 32'd0) begin fails++; $display("FAIL midreset_total got %0d want 0", d_tot[0]); end
      repeat (3) step(1'b0);
      rst_n = 1'b1;
      repeat (3) send(4, 4);
      wait_strobe(ok);
      tests++; if (!ok || m_e != 100) begin fails++; $display("FAIL midreset_strobe_cycle got %0d want 100", m_e); end
      tests++; if (d_pc[0] !== 16'd3) begin fails++; $display("FAIL midreset_count got %0d want 3", d_pc[0]); end
      tests++; if (d_tot[0] !== 32'd3) begin fails++; $display("FAIL midreset_total_after got %0d want 3", d_tot[0]); end
   endtask

   task automatic test_cadence();
      step(1'b0);
      tests++; if (strobe_mis != 0) begin fails++; $display("FAIL strobe_timing got %0d mismatched cycles want 0", strobe_mis); end
   endtask

   initial begin
      test_reset();
      test_clean_pulses();
      test_glitch();
      test_scale_clip();
      test_terminal_pulse();
      test_enable();
      test_reset_mid();
      test_cadence();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/photon_pulse_counter.md
# photon_pulse_counter

Front-end counter that turns the photon detector's asynchronous pulse line into one 16-bit count per fixed gate window, scaled and clipped to the histogram bar range. It sits directly upstream of the shift-and-draw stage: `oPulseCounter` and `oDataUpdate` drive that stage's `iPulseCounter` and `iDataUpdate`. A 32-bit saturating running total is kept for diagnostics.

## Interface
- GATE_CYCLES, 5_000_000, gate window length in clk cycles (100 ms at 50 MHz); minimum 4
- MIN_WIDTH, 2, consecutive synchronized-high cycles needed to qualify a pulse; range 1..15
- SCALE_SHIFT, 0, right shift applied to the window count before clipping; range 0..15
- OUT_MAX, 216, clip ceiling for `oPulseCounter` (bar pixel span 12..228)

- clk  in  1  system clock
- rst_n  in  1  asynchronous, active-low reset
- en  in  1  counting enable
- iPulse  in  1  raw detector pulse, asynchronous to clk
- oPulseCounter  out  16  scaled, clipped count of the last completed window
- oDataUpdate  out  1  one-cycle strobe: `oPulseCounter` has just been updated
- oClipped  out  1  last window's scaled count exceeded OUT_MAX
- oWinOverflow  out  1  last window's raw count saturated at 16'hFFFF
- oTotalCount  out  32  saturating count of all qualified pulses since reset

## Operation
- **Synchronizer.** `iPulse` passes through a 2-FF synchronizer, giving `p_s`. The synchronizer runs regardless of `en`.
- **Qualifier.** A 4-bit width counter increments while `p_s`=1 and clears when `p_s`=0.
  - A pulse qualifies on the cycle the width counter reaches MIN_WIDTH, and only once per high level.
  - A new pulse is counted only after `p_s` has returned to 0 for at least one cycle.
  - Highs shorter than MIN_WIDTH are discarded.
- **Gate counter.** Runs 0..GATE_CYCLES-1 while `en`=1, then wraps to 0.
- **Window counter.** 16-bit, saturating at 16'hFFFF. It sets an internal overflow bit if a qualified pulse arrives while already saturated.
- **Terminal cycle** (gate counter = GATE_CYCLES-1):
  - compute `s = win_cnt >> SCALE_SHIFT`
  - register `oPulseCounter = (s > OUT_MAX) ? OUT_MAX : s`, `oClipped = (s > OUT_MAX)`, `oWinOverflow = overflow bit`
  - assert `oDataUpdate`
  - clear the window counter and overflow bit
- **Pulse on the terminal cycle.** It is excluded from the closing window and counts as 1 in the new window (window counter loads 1, not 0).
- **en=0.** Gate counter, window counter and overflow bit are held at 0. No strobe is issued; outputs hold their last values. The qualifier still tracks, so a pulse high across re-enable is not double-counted. Qualified pulses while en=0 are not counted anywhere.
- **en rising.** A full window starts with the gate counter at 0.
- **oTotalCount.** Increments on every qualified pulse while en=1 and saturates at 32'hFFFF_FFFF. Cleared only by reset.
- **Widths.** All internal arithmetic is unsigned. The gate counter is 32-bit. Clip compare is 16-bit.

## Timing
- **Reset:** all outputs, counters, synchronizer and qualifier state go to 0 immediately and asynchronously. Reset mid-window discards the partial count; the first window after release starts at gate 0 (if en=1).
- **Pin-to-qualify latency:** 2 (sync) + MIN_WIDTH cycles after `iPulse` rises.
- **First strobe:** with en held at 1 from cycle 0, `oDataUpdate` is high in cycle GATE_CYCLES (counting the first enabled edge as cycle 1), for exactly one clk.
- **Strobe cadence:** then every GATE_CYCLES cycles.
- **Output alignment:** `oPulseCounter`, `oClipped` and `oWinOverflow` change on the same edge that raises `oDataUpdate`, and hold stable until the next strobe. The consumer samples them while the strobe is high; no acknowledge exists.
- **Terminal cycle with en falling:** if en falls on the terminal cycle, the strobe still fires (registered from that cycle).

## Test plan
- **Clean pulses.** GATE_CYCLES=100, MIN_WIDTH=2; 10 pulses, 4 high / 4 low, inside window 1 -> single strobe at cycle 100, `oPulseCounter`=10, `oClipped`=0, `oTotalCount`=10.
- **Glitch rejection.** 6 one-cycle highs, then one 5-cycle high, in one window -> `oPulseCounter`=1. A 40-cycle high counts 1, not 20.
- **Scale and clip.** SCALE_SHIFT=1, 9 pulses -> 4. With OUT_MAX=3, 9 pulses and SCALE_SHIFT=0 -> `oPulseCounter`=3, `oClipped`=1.
- **Terminal-cycle pulse.** Pulse qualifies exactly on gate=99 -> closing window reports its prior count (e.g. 2); next window with no further pulses reports 1.
- **Enable gating.** en dropped at gate=50 with 3 pulses counted, 5 pulses while low, en raised -> no strobe while low. The next strobe comes 100 cycles after re-enable and reports only pulses after re-enable. `oTotalCount` excludes the 5 pulses.
- **Reset mid-window.** rst_n low at gate=70 after 4 pulses -> all outputs 0 immediately. After release, the first strobe at cycle 100 reports only post-reset pulses.
